// File: rtl/flit_buffer.sv
// Flit FIFO: a flit pushed into an empty buffer appears on OUT one cycle later.
// IN_READY comes only from registered occupancy and FLUSH; drop/accept counters.
module flit_buffer #(
   parameter int W_FLIT = 8,
   parameter int W_DIR  = 5,
   parameter int DEPTH  = 4,
   parameter int W_CNT  = 8
) (
   input  logic                     CLK,
   input  logic                     RST_X,
   input  logic [W_FLIT-1:0]        IN,
   output logic                     IN_READY,
   input  logic                     FLUSH,
   output logic [W_FLIT-1:0]        OUT,
   output logic [W_DIR-1:0]         OUT_DIR,
   input  logic                     OUT_READY,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic [1:0]               STATE,
   output logic [W_CNT-1:0]         CNT,
   output logic [W_CNT-1:0]         DROP
);

   localparam int W_PTR = $clog2(DEPTH);
   localparam int W_LVL = W_PTR + 1;
   localparam logic [W_LVL-1:0] C_FULL = W_LVL'(DEPTH);

   localparam logic [1:0] S_EMPTY  = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_FULL   = 2'd2;

   logic [W_FLIT-1:0] r_mem [DEPTH];
   logic [W_PTR-1:0]  r_wptr;
   logic [W_PTR-1:0]  r_rptr;
   logic [W_LVL-1:0]  r_level;
   logic [1:0]        r_state;
   logic              r_ready_en;
   logic [W_CNT-1:0]  r_cnt;
   logic [W_CNT-1:0]  r_drop;

   logic [W_LVL-1:0]  w_level_nxt;
   logic [1:0]        w_state_nxt;
   logic              w_offer;
   logic              w_push;
   logic              w_pop;

   assign w_offer  = IN[W_FLIT-1];
   // r_ready_en keeps IN_READY low until the first edge after reset release
   assign IN_READY = r_ready_en & (r_level != C_FULL) & ~FLUSH;
   assign w_push   = w_offer & IN_READY;

   assign OUT      = (r_level != '0) ? r_mem[r_rptr] : '0;
   assign OUT_DIR  = OUT[W_FLIT-2 -: W_DIR];
   assign w_pop    = OUT[W_FLIT-1] & OUT_READY & ~FLUSH;

   assign LEVEL    = r_level;
   assign STATE    = r_state;
   assign CNT      = r_cnt;
   assign DROP     = r_drop;

   always_comb begin
      w_level_nxt = r_level;
      if (FLUSH)
         w_level_nxt = '0;
      else if (w_push && !w_pop)
         w_level_nxt = r_level + W_LVL'(1);
      else if (w_pop && !w_push)
         w_level_nxt = r_level - W_LVL'(1);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY:  if (w_push) w_state_nxt = S_ACTIVE;
         S_ACTIVE: begin
            if (w_level_nxt == C_FULL)
               w_state_nxt = S_FULL;
            else if (w_level_nxt == '0)
               w_state_nxt = S_EMPTY;
         end
         S_FULL:   if (w_pop) w_state_nxt = S_ACTIVE;
         default:  w_state_nxt = S_EMPTY;
      endcase
      if (FLUSH)
         w_state_nxt = S_EMPTY;
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_state    <= S_EMPTY;
         r_ready_en <= 1'b0;
         r_cnt      <= '0;
         r_drop     <= '0;
      end else begin
         r_ready_en <= 1'b1;
         r_level    <= w_level_nxt;
         r_state    <= w_state_nxt;
         if (FLUSH) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + W_PTR'(1);
            if (w_pop)  r_rptr <= r_rptr + W_PTR'(1);
         end
         if (w_push)
            r_cnt <= r_cnt + W_CNT'(1);
         if (w_offer && !IN_READY && (r_drop != '1))
            r_drop <= r_drop + W_CNT'(1);
      end
   end

   // Storage needs no reset: OUT is gated by r_level
   always_ff @(posedge CLK) begin
      if (w_push)
         r_mem[r_wptr] <= IN;
   end

endmodule

// File: tb/tb_flit_buffer.sv
// Directed bench for flit_buffer with default parameters.
module tb_flit_buffer;

   logic       CLK = 1'b0;
   logic       RST_X;
   logic [7:0] IN;
   logic       IN_READY;
   logic       FLUSH;
   logic [7:0] OUT;
   logic [4:0] OUT_DIR;
   logic       OUT_READY;
   logic [2:0] LEVEL;
   logic [1:0] STATE;
   logic [7:0] CNT;
   logic [7:0] DROP;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] q[$];
   logic [7:0] nxt;
   logic [7:0] exp_cnt;
   logic       exp_rdy;
   logic [7:0] head;

   always #5 CLK = ~CLK;

   flit_buffer #(.W_FLIT(8), .W_DIR(5), .DEPTH(4), .W_CNT(8)) u_dut (
      .CLK(CLK), .RST_X(RST_X), .IN(IN), .IN_READY(IN_READY), .FLUSH(FLUSH),
      .OUT(OUT), .OUT_DIR(OUT_DIR), .OUT_READY(OUT_READY), .LEVEL(LEVEL),
      .STATE(STATE), .CNT(CNT), .DROP(DROP)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      RST_X = 1'b0; IN = '0; FLUSH = 1'b0; OUT_READY = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_level", LEVEL, 0);
      chk("rst_state", STATE, 0);
      chk("rst_out", OUT, 0);
      chk("rst_dir", OUT_DIR, 0);
      chk("rst_cnt", CNT, 0);
      chk("rst_drop", DROP, 0);
      chk("rst_ready", IN_READY, 0);

      RST_X = 1'b1;
      @(negedge CLK);
      chk("ready_after_rst", IN_READY, 1);

      // single push, 1-cycle latency
      IN = 8'h85;
      @(negedge CLK);
      IN = '0;
      chk("lat_out", OUT, 8'h85);
      chk("lat_dir", OUT_DIR, 5'h01);
      chk("lat_level", LEVEL, 1);
      chk("lat_state", STATE, 1);
      chk("lat_cnt", CNT, 1);

      OUT_READY = 1'b1;
      @(negedge CLK);
      OUT_READY = 1'b0;
      chk("pop_level", LEVEL, 0);
      chk("pop_out", OUT, 0);
      chk("pop_state", STATE, 0);

      // invalid word is ignored
      IN = 8'h7F;
      @(negedge CLK);
      IN = '0;
      chk("inv_level", LEVEL, 0);
      chk("inv_cnt", CNT, 1);
      chk("inv_drop", DROP, 0);

      // fill to full
      for (int k = 1; k <= 4; k++) begin
         IN = 8'h80 + 8'(k);
         @(negedge CLK);
      end
      IN = '0;
      chk("full_level", LEVEL, 4);
      chk("full_state", STATE, 2);
      chk("full_ready", IN_READY, 0);
      chk("full_out", OUT, 8'h81);
      chk("full_cnt", CNT, 5);

      IN = 8'h85;
      @(negedge CLK);
      IN = '0;
      chk("drop_one", DROP, 1);
      chk("drop_level", LEVEL, 4);
      chk("drop_out", OUT, 8'h81);

      // streaming from full, pointer wrap
      q = '{8'h81, 8'h82, 8'h83, 8'h84};
      nxt = 8'hC0;
      exp_cnt = 8'd5;
      for (int i = 0; i < 10; i++) begin
         head = (q.size() != 0) ? q[0] : 8'h00;
         chk("stream_out", OUT, head);
         chk("stream_dir", OUT_DIR, head[6:2]);
         chk("stream_level", LEVEL, q.size());
         exp_rdy = (q.size() != 4);
         chk("stream_ready", IN_READY, exp_rdy);
         OUT_READY = 1'b1;
         IN = exp_rdy ? nxt : 8'h00;
         if (q.size() != 0) void'(q.pop_front());
         if (exp_rdy) begin
            q.push_back(nxt);
            nxt++;
            exp_cnt++;
         end
         @(negedge CLK);
      end
      OUT_READY = 1'b0;
      IN = '0;
      chk("pre_flush_level", LEVEL, 3);
      chk("pre_flush_out", OUT, q[0]);

      // flush with a valid flit offered
      FLUSH = 1'b1;
      IN = 8'hAA;
      #1;
      chk("flush_ready", IN_READY, 0);
      @(negedge CLK);
      FLUSH = 1'b0;
      IN = '0;
      chk("flush_level", LEVEL, 0);
      chk("flush_out", OUT, 0);
      chk("flush_state", STATE, 0);
      chk("flush_cnt", CNT, exp_cnt);
      chk("flush_drop", DROP, 2);

      // counter wrap after 256 pushes
      RST_X = 1'b0;
      @(negedge CLK);
      RST_X = 1'b1;
      @(negedge CLK);
      OUT_READY = 1'b1;
      for (int i = 0; i < 256; i++) begin
         IN = 8'h80 | 8'(i);
         @(negedge CLK);
         if (i == 254) chk("cnt_255", CNT, 255);
      end
      IN = '0;
      chk("cnt_wrap", CNT, 0);
      chk("wrap_level", LEVEL, 1);
      chk("wrap_out", OUT, 8'hFF);
      @(negedge CLK);
      OUT_READY = 1'b0;
      chk("wrap_drain", LEVEL, 0);

      // 4 accepted then 300 dropped
      for (int i = 0; i < 304; i++) begin
         IN = 8'h90;
         @(negedge CLK);
      end
      chk("drop_sat", DROP, 255);
      chk("drop_sat_cnt", CNT, 4);
      chk("drop_sat_level", LEVEL, 4);

      // asynchronous reset between edges
      #2;
      RST_X = 1'b0;
      #1;
      chk("arst_out", OUT, 0);
      chk("arst_dir", OUT_DIR, 0);
      chk("arst_level", LEVEL, 0);
      chk("arst_state", STATE, 0);
      chk("arst_cnt", CNT, 0);
      chk("arst_drop", DROP, 0);
      chk("arst_ready", IN_READY, 0);
      IN = '0;
      @(negedge CLK);
      RST_X = 1'b1;
      @(negedge CLK);
      chk("arst_ready_rise", IN_READY, 1);
      chk("arst_level_after", LEVEL, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
